// File: rtl/axi_mem_slave.sv
`default_nettype none
// ============================================================================
// axi_mem_slave : AXI4 slave word memory, independent write/read FSMs.
// Optional macro AXI_MEM_RANGE_CHECK_EN: SLVERR for beats above the array.
// Revision 1.0
// ============================================================================
module axi_mem_slave #(
    parameter int MEM_DEPTH_LOG2 = 12,
    parameter int ID_WIDTH       = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ID_WIDTH-1:0] axi_awid,
    input  logic [31:0]         axi_awaddr,
    input  logic [7:0]          axi_awlen,
    input  logic [2:0]          axi_awsize,
    input  logic [1:0]          axi_awburst,
    input  logic                axi_awlock,
    input  logic [3:0]          axi_awcache,
    input  logic [2:0]          axi_awprot,
    input  logic [3:0]          axi_awqos,
    input  logic                axi_awvalid,
    output logic                axi_awready,
    input  logic [31:0]         axi_wdata,
    input  logic [3:0]          axi_wstrb,
    input  logic                axi_wlast,
    input  logic                axi_wvalid,
    output logic                axi_wready,
    output logic [ID_WIDTH-1:0] axi_bid,
    output logic [1:0]          axi_bresp,
    output logic                axi_bvalid,
    input  logic                axi_bready,
    input  logic [ID_WIDTH-1:0] axi_arid,
    input  logic [31:0]         axi_araddr,
    input  logic [7:0]          axi_arlen,
    input  logic [2:0]          axi_arsize,
    input  logic [1:0]          axi_arburst,
    input  logic                axi_arlock,
    input  logic [3:0]          axi_arcache,
    input  logic [2:0]          axi_arprot,
    input  logic [3:0]          axi_arqos,
    input  logic                axi_arvalid,
    output logic                axi_arready,
    output logic [ID_WIDTH-1:0] axi_rid,
    output logic [31:0]         axi_rdata,
    output logic [1:0]          axi_rresp,
    output logic                axi_rlast,
    output logic                axi_rvalid,
    input  logic                axi_rready
);

    localparam int         c_depth       = 1 << MEM_DEPTH_LOG2;
    localparam logic [1:0] c_resp_okay   = 2'b00;
    localparam logic [1:0] c_resp_slverr = 2'b10;
    localparam logic [1:0] c_burst_fixed = 2'b00;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_FETCH = 2'd1, R_DATA = 2'd2} rstate_t;

    wstate_t             r_wstate, w_wstate_nxt;
    logic [29:0]         r_waddr, w_waddr_nxt;
    logic [7:0]          r_wcnt, w_wcnt_nxt;
    logic [1:0]          r_wburst, w_wburst_nxt;
    logic                r_werr, w_werr_nxt;
    logic                r_awready, w_awready_nxt;
    logic                r_wready, w_wready_nxt;
    logic                r_bvalid, w_bvalid_nxt;
    logic [1:0]          r_bresp, w_bresp_nxt;
    logic [ID_WIDTH-1:0] r_bid, w_bid_nxt;
    logic                w_mem_we, w_wbeat_oor;

    rstate_t             r_rstate, w_rstate_nxt;
    logic [29:0]         r_raddr, w_raddr_nxt;
    logic [7:0]          r_rcnt, w_rcnt_nxt;
    logic [1:0]          r_rburst, w_rburst_nxt;
    logic                r_arready, w_arready_nxt;
    logic                r_rvalid, w_rvalid_nxt;
    logic                r_rlast, w_rlast_nxt;
    logic [1:0]          r_rresp, w_rresp_nxt;
    logic [ID_WIDTH-1:0] r_rid, w_rid_nxt;
    logic                w_mem_re, w_rbeat_oor;
    logic [31:0]         w_rdata;

    logic [MEM_DEPTH_LOG2-1:0] w_widx, w_ridx;
    assign w_widx = r_waddr[MEM_DEPTH_LOG2-1:0];
    assign w_ridx = r_raddr[MEM_DEPTH_LOG2-1:0];

`ifdef AXI_MEM_RANGE_CHECK_EN
    assign w_wbeat_oor = |r_waddr[29:MEM_DEPTH_LOG2];
    assign w_rbeat_oor = |r_raddr[29:MEM_DEPTH_LOG2];
`else
    assign w_wbeat_oor = 1'b0;
    assign w_rbeat_oor = 1'b0;
`endif

    // Write channel: the beat counter, not wlast, decides the end of the burst
    always_comb begin
        w_wstate_nxt  = r_wstate;
        w_waddr_nxt   = r_waddr;
        w_wcnt_nxt    = r_wcnt;
        w_wburst_nxt  = r_wburst;
        w_werr_nxt    = r_werr;
        w_awready_nxt = r_awready;
        w_wready_nxt  = r_wready;
        w_bvalid_nxt  = r_bvalid;
        w_bresp_nxt   = r_bresp;
        w_bid_nxt     = r_bid;
        w_mem_we      = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                w_awready_nxt = 1'b1;
                if (axi_awvalid && r_awready) begin
                    w_awready_nxt = 1'b0;
                    w_wready_nxt  = 1'b1;
                    w_bid_nxt     = axi_awid;
                    w_waddr_nxt   = axi_awaddr[31:2];
                    w_wcnt_nxt    = axi_awlen;
                    w_wburst_nxt  = axi_awburst;
                    w_werr_nxt    = 1'b0;
                    w_wstate_nxt  = W_DATA;
                end
            end
            W_DATA: begin
                if (axi_wvalid && r_wready) begin
                    w_mem_we   = rst && !w_wbeat_oor;
                    w_werr_nxt = r_werr | w_wbeat_oor;
                    if (r_wcnt == 8'd0) begin
                        w_wready_nxt = 1'b0;
                        w_bvalid_nxt = 1'b1;
                        w_bresp_nxt  = (r_werr || w_wbeat_oor) ? c_resp_slverr : c_resp_okay;
                        w_wstate_nxt = W_RESP;
                    end else begin
                        w_wcnt_nxt = r_wcnt - 8'd1;
                        if (r_wburst != c_burst_fixed) w_waddr_nxt = r_waddr + 30'd1;
                    end
                end
            end
            W_RESP: begin
                if (axi_bready && r_bvalid) begin
                    w_bvalid_nxt  = 1'b0;
                    w_awready_nxt = 1'b1;
                    w_wstate_nxt  = W_IDLE;
                end
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wstate  <= W_IDLE;
            r_waddr   <= '0;
            r_wcnt    <= '0;
            r_wburst  <= '0;
            r_werr    <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= '0;
            r_bid     <= '0;
        end else begin
            r_wstate  <= w_wstate_nxt;
            r_waddr   <= w_waddr_nxt;
            r_wcnt    <= w_wcnt_nxt;
            r_wburst  <= w_wburst_nxt;
            r_werr    <= w_werr_nxt;
            r_awready <= w_awready_nxt;
            r_wready  <= w_wready_nxt;
            r_bvalid  <= w_bvalid_nxt;
            r_bresp   <= w_bresp_nxt;
            r_bid     <= w_bid_nxt;
        end
    end

    // Read channel: one fetch cycle per beat, R outputs frozen while stalled
    always_comb begin
        w_rstate_nxt  = r_rstate;
        w_raddr_nxt   = r_raddr;
        w_rcnt_nxt    = r_rcnt;
        w_rburst_nxt  = r_rburst;
        w_arready_nxt = r_arready;
        w_rvalid_nxt  = r_rvalid;
        w_rlast_nxt   = r_rlast;
        w_rresp_nxt   = r_rresp;
        w_rid_nxt     = r_rid;
        w_mem_re      = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                w_arready_nxt = 1'b1;
                if (axi_arvalid && r_arready) begin
                    w_arready_nxt = 1'b0;
                    w_rid_nxt     = axi_arid;
                    w_raddr_nxt   = axi_araddr[31:2];
                    w_rcnt_nxt    = axi_arlen;
                    w_rburst_nxt  = axi_arburst;
                    w_rstate_nxt  = R_FETCH;
                end
            end
            R_FETCH: begin
                w_mem_re     = 1'b1;
                w_rvalid_nxt = 1'b1;
                w_rlast_nxt  = (r_rcnt == 8'd0);
                w_rresp_nxt  = w_rbeat_oor ? c_resp_slverr : c_resp_okay;
                w_rstate_nxt = R_DATA;
            end
            R_DATA: begin
                if (axi_rready && r_rvalid) begin
                    w_rvalid_nxt = 1'b0;
                    w_rlast_nxt  = 1'b0;
                    if (r_rcnt == 8'd0) begin
                        w_arready_nxt = 1'b1;
                        w_rstate_nxt  = R_IDLE;
                    end else begin
                        w_rcnt_nxt   = r_rcnt - 8'd1;
                        if (r_rburst != c_burst_fixed) w_raddr_nxt = r_raddr + 30'd1;
                        w_rstate_nxt = R_FETCH;
                    end
                end
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rstate  <= R_IDLE;
            r_raddr   <= '0;
            r_rcnt    <= '0;
            r_rburst  <= '0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rresp   <= '0;
            r_rid     <= '0;
        end else begin
            r_rstate  <= w_rstate_nxt;
            r_raddr   <= w_raddr_nxt;
            r_rcnt    <= w_rcnt_nxt;
            r_rburst  <= w_rburst_nxt;
            r_arready <= w_arready_nxt;
            r_rvalid  <= w_rvalid_nxt;
            r_rlast   <= w_rlast_nxt;
            r_rresp   <= w_rresp_nxt;
            r_rid     <= w_rid_nxt;
        end
    end

    // One array per byte lane; nonblocking read and write give read-before-write
    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_lane
            logic [7:0] r_lane [c_depth];
            logic [7:0] r_q;
            always_ff @(posedge clk) begin
                if (w_mem_we && axi_wstrb[g]) r_lane[w_widx] <= axi_wdata[8*g +: 8];
                if (!rst)          r_q <= 8'h00;
                else if (w_mem_re) r_q <= w_rbeat_oor ? 8'h00 : r_lane[w_ridx];
            end
            assign w_rdata[8*g +: 8] = r_q;
        end
    endgenerate

    assign axi_awready = r_awready;
    assign axi_wready  = r_wready;
    assign axi_bvalid  = r_bvalid;
    assign axi_bresp   = r_bresp;
    assign axi_bid     = r_bid;
    assign axi_arready = r_arready;
    assign axi_rvalid  = r_rvalid;
    assign axi_rlast   = r_rlast;
    assign axi_rresp   = r_rresp;
    assign axi_rid     = r_rid;
    assign axi_rdata   = w_rdata;

    logic w_unused;
    assign w_unused = &{1'b0, axi_awsize, axi_awlock, axi_awcache, axi_awprot, axi_awqos,
                        axi_awaddr[1:0], axi_wlast, axi_arsize, axi_arlock, axi_arcache,
                        axi_arprot, axi_arqos, axi_araddr[1:0], r_waddr, r_raddr};

endmodule
`default_nettype wire

// File: tb/tb_axi_mem_slave.sv
`default_nettype none
// ============================================================================
// tb_axi_mem_slave : vector table plus B/R scoreboards for axi_mem_slave
// Revision 1.0
// ============================================================================
module tb_axi_mem_slave;
    localparam int ID_W = 2;
    localparam int TMO  = 200;
`ifdef AXI_MEM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [ID_W-1:0] axi_awid = '0;
    logic [31:0]     axi_awaddr = '0;
    logic [7:0]      axi_awlen = '0;
    logic [2:0]      axi_awsize = 3'b010;
    logic [1:0]      axi_awburst = 2'b01;
    logic            axi_awvalid = 1'b0;
    logic            axi_awready;
    logic [31:0]     axi_wdata = '0;
    logic [3:0]      axi_wstrb = '0;
    logic            axi_wlast = 1'b0;
    logic            axi_wvalid = 1'b0;
    logic            axi_wready;
    logic [ID_W-1:0] axi_bid;
    logic [1:0]      axi_bresp;
    logic            axi_bvalid;
    logic            axi_bready = 1'b1;
    logic [ID_W-1:0] axi_arid = '0;
    logic [31:0]     axi_araddr = '0;
    logic [7:0]      axi_arlen = '0;
    logic [2:0]      axi_arsize = 3'b010;
    logic [1:0]      axi_arburst = 2'b01;
    logic            axi_arvalid = 1'b0;
    logic            axi_arready;
    logic [ID_W-1:0] axi_rid;
    logic [31:0]     axi_rdata;
    logic [1:0]      axi_rresp;
    logic            axi_rlast;
    logic            axi_rvalid;
    logic            axi_rready = 1'b1;

    always #5 clk = ~clk;

    axi_mem_slave #(.MEM_DEPTH_LOG2(12), .ID_WIDTH(ID_W)) dut (
        .clk(clk), .rst(rst),
        .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
        .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awlock(1'b0),
        .axi_awcache(4'h0), .axi_awprot(3'h0), .axi_awqos(4'h0),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
        .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arlock(1'b0),
        .axi_arcache(4'h0), .axi_arprot(3'h0), .axi_arqos(4'h0),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
        .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
    );

    typedef struct { logic [ID_W-1:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct { logic [ID_W-1:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_exp_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] strb; logic [31:0] exp; } vec_t;

    b_exp_t      bq[$];
    r_exp_t      rq[$];
    b_exp_t      b_e;
    r_exp_t      r_e;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] wbuf_data [16];
    logic [3:0]  wbuf_strb [16];
    logic [31:0] rbuf_exp  [16];
    vec_t        vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got no handshake expected one within %0d cycles", name, TMO);
    endtask

    always @(negedge clk) begin
        if (rst && axi_bvalid && axi_bready) begin
            chk("b_expected", 32'(bq.size() != 0), 32'd1);
            if (bq.size() != 0) begin
                b_e = bq.pop_front();
                chk("bresp", 32'(axi_bresp), 32'(b_e.resp));
                chk("bid", 32'(axi_bid), 32'(b_e.id));
            end
        end
        if (rst && axi_rvalid && axi_rready) begin
            chk("r_expected", 32'(rq.size() != 0), 32'd1);
            if (rq.size() != 0) begin
                r_e = rq.pop_front();
                chk("rdata", axi_rdata, r_e.data);
                chk("rresp", 32'(axi_rresp), 32'(r_e.resp));
                chk("rlast", 32'(axi_rlast), 32'(r_e.last));
                chk("rid", 32'(axi_rid), 32'(r_e.id));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_awready();
        int n = 0;
        while (!axi_awready && n < TMO) begin tick(); n++; end
        if (!axi_awready) timeout("awready");
    endtask

    task automatic wait_wready();
        int n = 0;
        while (!axi_wready && n < TMO) begin tick(); n++; end
        if (!axi_wready) timeout("wready");
    endtask

    task automatic wait_arready();
        int n = 0;
        while (!axi_arready && n < TMO) begin tick(); n++; end
        if (!axi_arready) timeout("arready");
    endtask

    task automatic wait_rvalid();
        int n = 0;
        while (!axi_rvalid && n < TMO) begin tick(); n++; end
        if (!axi_rvalid) timeout("rvalid");
    endtask

    task automatic drain();
        int n = 0;
        while ((bq.size() != 0 || rq.size() != 0) && n < TMO) begin tick(); n++; end
        if (bq.size() != 0 || rq.size() != 0) begin
            timeout("drain");
            bq.delete();
            rq.delete();
        end
    endtask

    task automatic aw_send(input logic [ID_W-1:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        axi_awid = id; axi_awaddr = addr; axi_awlen = len; axi_awburst = burst;
        axi_awvalid = 1'b1;
        wait_awready();
        tick();
        axi_awvalid = 1'b0;
    endtask

    task automatic ar_send(input logic [ID_W-1:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        axi_arid = id; axi_araddr = addr; axi_arlen = len; axi_arburst = burst;
        axi_arvalid = 1'b1;
        wait_arready();
        tick();
        axi_arvalid = 1'b0;
    endtask

    task automatic wr_burst(input logic [ID_W-1:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [1:0] burst, input logic err);
        b_exp_t e;
        e.id = id;
        e.resp = err ? 2'b10 : 2'b00;
        bq.push_back(e);
        aw_send(id, addr, len, burst);
        for (int b = 0; b <= int'(len); b++) begin
            axi_wdata = wbuf_data[b];
            axi_wstrb = wbuf_strb[b];
            axi_wlast = (b == int'(len));
            axi_wvalid = 1'b1;
            wait_wready();
            tick();
        end
        axi_wvalid = 1'b0;
        axi_wlast = 1'b0;
    endtask

    task automatic rd_burst(input logic [ID_W-1:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [1:0] burst, input logic err);
        r_exp_t e;
        for (int b = 0; b <= int'(len); b++) begin
            e.id = id;
            e.data = err ? 32'h0 : rbuf_exp[b];
            e.resp = err ? 2'b10 : 2'b00;
            e.last = (b == int'(len));
            rq.push_back(e);
        end
        ar_send(id, addr, len, burst);
    endtask

    task automatic wr1(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [31:0] data);
        wbuf_data[0] = data;
        wbuf_strb[0] = 4'hF;
        wr_burst(id, addr, 8'd0, 2'b01, 1'b0);
        drain();
    endtask

    task automatic rd1(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [31:0] exp);
        rbuf_exp[0] = exp;
        rd_burst(id, addr, 8'd0, 2'b01, 1'b0);
        drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish within 1 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF};
        vecs[1] = '{32'h0000_0014, 32'h0123_4567, 4'hF, 32'h0123_4567};
        vecs[2] = '{32'h0000_0014, 32'hAAAA_AAAA, 4'h1, 32'h0123_45AA};
        vecs[3] = '{32'h0000_0014, 32'hBBBB_BBBB, 4'h8, 32'hBB23_45AA};
        vecs[4] = '{32'h0000_0017, 32'h0000_0000, 4'h0, 32'hBB23_45AA};
        vecs[5] = '{32'h0000_3FFC, 32'hCAFE_F00D, 4'hF, 32'hCAFE_F00D};
        vecs[6] = '{32'h0000_1000, 32'h1234_5678, 4'hF, 32'h1234_5678};

        // reset state and release
        repeat (3) tick();
        chk("rst_ctrl", 32'({axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid, axi_rlast}), 32'd0);
        chk("rst_resp_ids", 32'({axi_bresp, axi_rresp, axi_bid, axi_rid}), 32'd0);
        chk("rst_rdata", axi_rdata, 32'd0);
        rst = 1'b1;
        tick();
        chk("rel_awready", 32'(axi_awready), 32'd1);
        chk("rel_arready", 32'(axi_arready), 32'd1);

        // single-beat vectors
        for (int i = 0; i < 7; i++) begin
            wbuf_data[0] = vecs[i].data;
            wbuf_strb[0] = vecs[i].strb;
            wr_burst(ID_W'(i), vecs[i].addr, 8'd0, 2'b01, 1'b0);
            drain();
            rbuf_exp[0] = vecs[i].exp;
            rd_burst(ID_W'(i + 1), vecs[i].addr, 8'd0, 2'b01, 1'b0);
            drain();
        end

        // AR handshake at N: rvalid low at N+1, high at N+2
        rbuf_exp[0] = 32'hDEAD_BEEF;
        rd_burst(2'd3, 32'h10, 8'd0, 2'b01, 1'b0);
        chk("lat_n1", 32'(axi_rvalid), 32'd0);
        tick();
        chk("lat_n2", 32'(axi_rvalid), 32'd1);
        drain();

        // INCR burst with partial strobe on beat 2
        wr1(2'd1, 32'h108, 32'hABCD_EF01);
        wbuf_data[0] = 32'h1111_1111; wbuf_strb[0] = 4'hF;
        wbuf_data[1] = 32'h2222_2222; wbuf_strb[1] = 4'hF;
        wbuf_data[2] = 32'h3333_3333; wbuf_strb[2] = 4'h3;
        wbuf_data[3] = 32'h4444_4444; wbuf_strb[3] = 4'hF;
        wr_burst(2'd2, 32'h100, 8'd3, 2'b01, 1'b0);
        drain();
        repeat (2) tick();
        chk("b_single", 32'(axi_bvalid), 32'd0);

        // read with 5-cycle stall on beat 1
        rbuf_exp[0] = 32'h1111_1111;
        rbuf_exp[1] = 32'h2222_2222;
        rbuf_exp[2] = 32'hABCD_3333;
        rbuf_exp[3] = 32'h4444_4444;
        axi_rready = 1'b0;
        rd_burst(2'd3, 32'h100, 8'd3, 2'b01, 1'b0);
        wait_rvalid();
        axi_rready = 1'b1;
        tick();
        axi_rready = 1'b0;
        wait_rvalid();
        for (int s = 0; s < 5; s++) begin
            chk("stall_rvalid", 32'(axi_rvalid), 32'd1);
            chk("stall_rdata", axi_rdata, 32'h2222_2222);
            chk("stall_rlast", 32'(axi_rlast), 32'd0);
            chk("stall_rid", 32'(axi_rid), 32'd3);
            tick();
        end
        axi_rready = 1'b1;
        drain();

        // WRAP write and type-3 read behave as INCR; FIXED read repeats
        wbuf_data[0] = 32'h5A5A_0000; wbuf_strb[0] = 4'hF;
        wbuf_data[1] = 32'h5A5A_0001; wbuf_strb[1] = 4'hF;
        wr_burst(2'd0, 32'h300, 8'd1, 2'b10, 1'b0);
        drain();
        rbuf_exp[0] = 32'h5A5A_0000;
        rbuf_exp[1] = 32'h5A5A_0001;
        rd_burst(2'd1, 32'h300, 8'd1, 2'b11, 1'b0);
        drain();
        rbuf_exp[1] = 32'h5A5A_0000;
        rd_burst(2'd2, 32'h300, 8'd1, 2'b00, 1'b0);
        drain();

        // FIXED write: last beat wins, neighbour untouched
        wr1(2'd0, 32'h24, 32'h2424_2424);
        wbuf_data[0] = 32'hA0A0_A0A0; wbuf_strb[0] = 4'hF;
        wbuf_data[1] = 32'hB0B0_B0B0; wbuf_strb[1] = 4'hF;
        wbuf_data[2] = 32'hC0C0_C0C0; wbuf_strb[2] = 4'hF;
        wr_burst(2'd1, 32'h20, 8'd2, 2'b00, 1'b0);
        drain();
        rbuf_exp[0] = 32'hC0C0_C0C0;
        rbuf_exp[1] = 32'h2424_2424;
        rd_burst(2'd2, 32'h20, 8'd1, 2'b01, 1'b0);
        drain();

        // same-cycle write and array read of 0x30
        wr1(2'd0, 32'h30, 32'h5);
        bq.push_back('{id: 2'd2, resp: 2'b00});
        rq.push_back('{id: 2'd1, data: 32'h5, resp: 2'b00, last: 1'b1});
        chk("coll_ready", 32'({axi_awready, axi_arready}), 32'd3);
        axi_awid = 2'd2; axi_awaddr = 32'h30; axi_awlen = 8'd0; axi_awburst = 2'b01; axi_awvalid = 1'b1;
        axi_arid = 2'd1; axi_araddr = 32'h30; axi_arlen = 8'd0; axi_arburst = 2'b01; axi_arvalid = 1'b1;
        axi_wdata = 32'h9; axi_wstrb = 4'hF; axi_wlast = 1'b1; axi_wvalid = 1'b1;
        tick();
        axi_awvalid = 1'b0;
        axi_arvalid = 1'b0;
        chk("coll_wready", 32'(axi_wready), 32'd1);
        tick();
        axi_wvalid = 1'b0;
        axi_wlast = 1'b0;
        drain();
        rd1(2'd3, 32'h30, 32'h9);

        // reset after beat 1 of a 4-beat write
        for (int b = 0; b < 4; b++) begin
            wbuf_data[b] = 32'hF0F0_F0F0;
            wbuf_strb[b] = 4'hF;
        end
        wr_burst(2'd2, 32'h200, 8'd3, 2'b01, 1'b0);
        drain();
        aw_send(2'd1, 32'h200, 8'd3, 2'b01);
        axi_wdata = 32'hD000_0000; axi_wstrb = 4'hF; axi_wvalid = 1'b1;
        wait_wready();
        tick();
        axi_wdata = 32'hD000_0001;
        wait_wready();
        tick();
        rst = 1'b0;
        axi_wvalid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("mid_rst_ctrl", 32'({axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid, axi_rlast}), 32'd0);
            chk("mid_rst_resp_ids", 32'({axi_bresp, axi_rresp, axi_bid, axi_rid}), 32'd0);
            chk("mid_rst_rdata", axi_rdata, 32'd0);
        end
        rst = 1'b1;
        tick();
        chk("mid_rel_ready", 32'({axi_awready, axi_arready}), 32'd3);
        chk("mid_rel_bvalid", 32'(axi_bvalid), 32'd0);
        rbuf_exp[0] = 32'hD000_0000;
        rbuf_exp[1] = 32'hD000_0001;
        rbuf_exp[2] = 32'hF0F0_F0F0;
        rbuf_exp[3] = 32'hF0F0_F0F0;
        rd_burst(2'd0, 32'h200, 8'd3, 2'b01, 1'b0);
        drain();

        // address above the array: SLVERR when checked, aliasing otherwise
        wr1(2'd0, 32'h0, 32'h1122_3344);
        wbuf_data[0] = 32'h7777_7777;
        wbuf_strb[0] = 4'hF;
        wr_burst(2'd1, 32'h4000, 8'd0, 2'b01, RC);
        drain();
        rd1(2'd2, 32'h0, RC ? 32'h1122_3344 : 32'h7777_7777);
        rbuf_exp[0] = 32'h7777_7777;
        rd_burst(2'd3, 32'h4000, 8'd0, 2'b01, RC);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_mem_slave.md
Name: axi_mem_slave

Overview:
- AXI4 slave memory that terminates the 32-bit AXI master port of a processor-plus-AXI-bridge wrapper (one instance per processor, `AXI_ID` = `PROC_ID`).
- Backs the match tables, action tables and op storage that the processor reads and writes through its memory interface.
- Holds an internal dual-port word array.
- Write and read channels are served by independent FSMs.

Parameters:
- MEM_DEPTH_LOG2, 12, log2 of the number of 32-bit words in the array.
- ID_WIDTH, 1, width of the AXI ID fields.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- axi_awid  in  ID_WIDTH  write address ID
- axi_awaddr  in  32  write byte address
- axi_awlen  in  8  beats minus 1
- axi_awsize  in  3  beat size (only 3'b010 meaningful)
- axi_awburst  in  2  burst type
- axi_awlock/awcache/awprot/awqos  in  1/4/3/4  accepted, ignored
- axi_awvalid  in  1
- axi_awready  out  1
- axi_wdata  in  32
- axi_wstrb  in  4
- axi_wlast  in  1
- axi_wvalid  in  1
- axi_wready  out  1
- axi_bid  out  ID_WIDTH
- axi_bresp  out  2
- axi_bvalid  out  1
- axi_bready  in  1
- axi_arid  in  ID_WIDTH
- axi_araddr  in  32
- axi_arlen  in  8
- axi_arsize  in  3
- axi_arburst  in  2
- axi_arlock/arcache/arprot/arqos  in  1/4/3/4  ignored
- axi_arvalid  in  1
- axi_arready  out  1
- axi_rid  out  ID_WIDTH
- axi_rdata  out  32
- axi_rresp  out  2
- axi_rlast  out  1
- axi_rvalid  out  1
- axi_rready  in  1

Behaviour:
- Reset (rst==0 at a clk edge):
  - Both FSMs go to IDLE.
  - awready, wready, bvalid, arready, rvalid, rlast = 0.
  - bresp, rresp, bid, rid, rdata = 0.
  - Array contents are not cleared.
  - First cycle after release: awready = arready = 1.
- Reset mid-burst: the transaction is abandoned, no B/R response is issued, and beats already written stay written.
- Word index = addr[MEM_DEPTH_LOG2+1:2]. Low 2 bits are ignored. The index wraps modulo depth.
- Size is always treated as 4 bytes.
- Burst handling:
  - FIXED (00): address held for every beat.
  - INCR (01): address +1 word per beat.
  - WRAP (10): treated as INCR.
  - 11: treated as INCR.
- Write FSM, W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1. On awvalid&awready, latch id, index, len and burst; wready=1 next cycle; go to W_DATA.
  - W_DATA: each wvalid&wready writes the bytes selected by wstrb (strb[i] -> data[8i+7:8i]) and decrements the beat counter.
  - The beat counter is authoritative and wlast is ignored. On the final beat: wready=0, bvalid=1, bresp=00, bid=latched id; go to W_RESP.
  - W_RESP: hold bvalid until bready; then awready=1 next cycle; go to W_IDLE.
- Read FSM, R_IDLE -> R_FETCH -> R_DATA:
  - R_IDLE: arready=1. On handshake, latch fields; go to R_FETCH.
  - R_FETCH: issue the synchronous array read (1-cycle latency); go to R_DATA.
  - R_DATA: rvalid=1, rdata registered, rid=latched, rresp=00, rlast=1 iff this is the final beat. Hold all R outputs stable until rready.
  - On rvalid&rready: if the final beat, go to R_IDLE (arready=1 next cycle); otherwise advance the address and go to R_FETCH.
  - Throughput is 1 beat per 2 cycles with no backpressure.
  - Latency: AR handshake at cycle N -> first rvalid at N+2.
- Simultaneous write and read to the same word in the same cycle: the read returns the old data (read-before-write).
- Write and read channels are fully independent. The block never stalls one for the other.
- awready is 0 outside W_IDLE and arready is 0 outside R_IDLE, so there is one outstanding transaction per direction.

Optional Feature:
- Macro: AXI_MEM_RANGE_CHECK_EN.
- When defined, a transaction whose start address or any beat address has awaddr/araddr[31:MEM_DEPTH_LOG2+2] != 0 gets SLVERR (2'b10):
  - Writes: the whole burst is still accepted, offending beats are not written, and bresp = SLVERR if any beat was out of range.
  - Reads: rdata = 32'h0 and rresp = SLVERR on offending beats.
- When undefined: upper bits are ignored (aliasing) and the response is always OKAY.

Test Plan:
- Single write then read:
  - Stimulus: AW addr 0x10 len 0, W data 0xDEADBEEF strb 4'hF; then AR addr 0x10 len 0.
  - Required: bresp 00 with bid echoed; rdata 0xDEADBEEF, rlast=1, rvalid 2 cycles after the AR handshake.
- Burst write with strobes:
  - Stimulus: INCR len 3 at 0x100, data 0x11111111..0x44444444, strb 4'h3 on beat 2.
  - Required: read-back gives 0x11111111, 0x22222222, old[31:16]|0x3333, 0x44444444; exactly one B response.
- Read backpressure:
  - Stimulus: INCR len 3 read with rready low for 5 cycles on beat 1.
  - Required: rdata, rid and rlast stay stable while stalled; 4 beats in order; rlast only on beat 3.
- FIXED burst and same-cycle collision:
  - FIXED len 2 write to 0x20 with data A, B, C -> the word reads C.
  - Read and write of 0x30 (old 0x5, new 0x9) in the same cycle -> rdata 0x5; a later read returns 0x9.
- Reset mid-burst:
  - Stimulus: assert rst low after beat 1 of a len 3 write.
  - Required: no bvalid; all outputs 0 during reset; awready=arready=1 the cycle after release; beats 0 and 1 are persisted.
- Range check (macro defined, MEM_DEPTH_LOG2=12):
  - Write to 0x4000 -> bresp 10 and memory unchanged.
  - Read from 0x4000 -> rdata 0, rresp 10.
  - Macro undefined -> the same accesses alias to 0x0 and respond OKAY.
